mul_ucode_ctrl: RTL and testbench

- Multi-cycle microcode sequencer for the multiply-immediate instruction (opcode 7'b0010000). Computes Rd = Rs * imm by shift-add.
- Triggered by the decoder's multiply trigger. Latches dest, source and immediate fields.
- Reads the source register through a dedicated register-file read port, iterates, then writes the result back.
- Stalls fetch/decode while running.

---
 rtl/mul_ucode_ctrl.sv | 82 ++++++++
 tb/tb_mul_ucode_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul_ucode_ctrl.sv
// mul_ucode_ctrl: shift-add microcode sequencer for multiply-immediate, Rd = Rs * imm
module mul_ucode_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [REG_AW-1:0] src_reg,
  input  logic [DATA_W-1:0] imm,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              ovf
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]          state;
  logic [REG_AW-1:0]   dest_q, src_q;
  logic [DATA_W-1:0]   imm_q, mplier;
  logic [2*DATA_W-1:0] acc, mcand;
  logic [CW-1:0]       cnt;
  logic                ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dest_q <= '0;
      src_q  <= '0;
      imm_q  <= '0;
      mplier <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= ovf;
      if (state == IDLE && start) begin
        dest_q <= dest_reg;
        src_q  <= src_reg;
        imm_q  <= imm;
        state  <= READ;
      end else if (state == READ) begin
        mcand  <= {{DATA_W{1'b0}}, rf_rdata};
        acc    <= '0;
        cnt    <= '0;
        mplier <= imm_q;
        state  <= (imm_q == '0) ? WRITE : MUL;
      end else if (state == MUL) begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // stop once no multiplier bits remain, or after DATA_W iterations
        state  <= (mplier[DATA_W-1:1] == '0 || cnt == CW'(DATA_W - 1)) ? WRITE : MUL;
      end else if (state == WRITE) begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    busy     = state != IDLE;
    stall    = start | busy;
    rf_we    = state == WRITE;
    done     = rf_we;
    rf_raddr = src_q;
    rf_waddr = dest_q;
    rf_wdata = acc[DATA_W-1:0];
    ovf      = rf_we ? |acc[2*DATA_W-1:DATA_W] : ovf_q;
  end
endmodule

// File: tb/tb_mul_ucode_ctrl.sv
// tb_mul_ucode_ctrl: directed bench with a cycle-offset/product model and a bench-side register file
module tb_mul_ucode_ctrl;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  dest_reg, src_reg, rf_raddr, rf_waddr;
  logic [15:0] imm, rf_rdata, rf_wdata;
  logic        rf_we, stall, busy, done, ovf;
  logic [15:0] rf [16];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  int n_chk = 0, n_fail = 0;

  mul_ucode_ctrl #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dest_reg(dest_reg), .src_reg(src_reg), .imm(imm),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_we(rf_we), .stall(stall), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (ld_en) rf[ld_addr] <= ld_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int write_offset(input logic [15:0] v);
    int k = 0;
    for (int i = 0; i < 16; i++) if (v[i]) k = i + 1;
    return (v == 16'd0) ? 2 : k + 2;
  endfunction

  // model: an accepted start writes the full product exactly write_offset cycles later
  logic        m_active, m_ovf;
  int          m_phase, m_off;
  logic [3:0]  m_dest;
  logic [31:0] m_prod;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_ovf    <= 1'b0;
      m_phase  <= 0;
      m_off    <= 0;
      m_dest   <= '0;
      m_prod   <= '0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_phase  <= 1;
        m_off    <= write_offset(imm);
        m_dest   <= dest_reg;
        m_prod   <= 32'(rf[src_reg]) * 32'(imm);
      end
    end else if (m_phase == m_off) begin
      m_active <= 1'b0;
      m_ovf    <= |m_prod[31:16];
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    logic in_wr;
    in_wr = m_active && (m_phase == m_off);
    if (rst) begin
      chk("busy", busy, m_active);
      chk("stall", stall, start | m_active);
      chk("rf_we", rf_we, in_wr);
      chk("done", done, in_wr);
      chk("ovf", ovf, in_wr ? |m_prod[31:16] : m_ovf);
      if (in_wr) begin
        chk("rf_waddr", rf_waddr, m_dest);
        chk("rf_wdata", rf_wdata, m_prod[15:0]);
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // called #1 after a rising edge; that cycle is cycle 0 of the operation
  task automatic op(input logic [3:0] s, input logic [3:0] d, input logic [15:0] im,
                    input int ecyc, input logic [15:0] edata, input logic eovf, input int intr);
    int cyc;
    start = 1'b1; src_reg = s; dest_reg = d; imm = im;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (!rf_we && cyc < 40) begin
      if (cyc == intr) begin
        start = 1'b1; src_reg = s + 4'd1; dest_reg = d + 4'd1; imm = im + 16'd3;
      end
      @(posedge clk); #1;
      start = 1'b0; cyc++;
    end
    chk("write_cycle", cyc, ecyc);
    chk("lit_waddr", rf_waddr, d);
    chk("lit_wdata", rf_wdata, edata);
    chk("lit_ovf", ovf, eovf);
    @(posedge clk); #1;
    chk("busy_after_write", busy, 1'b0);
    chk("rf_result", rf[d], edata);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dest_reg = '0; src_reg = '0; imm = '0;
    for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h0111);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_raddr", rf_raddr, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    load(4'd2, 16'd3);
    op(4'd2, 4'd5, 16'd5, 5, 16'd15, 1'b0, -1);
    load(4'd1, 16'h1234);
    op(4'd1, 4'd7, 16'd0, 2, 16'd0, 1'b0, -1);
    load(4'd1, 16'd1);
    op(4'd1, 4'd8, 16'h8000, 18, 16'h8000, 1'b0, -1);
    load(4'd3, 16'h0100);
    op(4'd3, 4'd9, 16'h0100, 11, 16'h0000, 1'b1, -1);
    chk("ovf_held", ovf, 1'b1);
    load(4'd3, 16'hFFFF);
    op(4'd3, 4'd3, 16'hFFFF, 18, 16'h0001, 1'b1, -1);
    load(4'd2, 16'd3);
    op(4'd2, 4'd5, 16'd5, 5, 16'd15, 1'b0, 2);
    chk("ignored_dest_untouched", rf[6], 16'h0666);
    load(4'd4, 16'd7);
    load(4'd6, 16'h0055);
    start = 1'b1; src_reg = 4'd4; dest_reg = 4'd6; imm = 16'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_stall", stall, 0);
    chk("abort_we", rf_we, 0);
    chk("abort_ovf", ovf, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_write", rf[6], 16'h0055);
    op(4'd4, 4'd4, 16'd6, 5, 16'd42, 1'b0, -1);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
